// File: rtl/float_rounder_pkg.sv
// float_rounder_pkg: shared types and window-limit helpers
// for the multi-channel float rounder.
package float_rounder_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC      = 2'd0,
        RND_HALF_UP    = 2'd1,
        RND_CONVERGENT = 2'd2
    } round_mode_t;

    // Largest value representable in an ow-bit output window.
    function automatic longint win_max(input int ow, input bit sgn);
        if (sgn)
            return (64'sd1 <<< (ow - 1)) - 64'sd1;
        return (64'sd1 <<< ow) - 64'sd1;
    endfunction

    // Smallest value representable in an ow-bit output window.
    function automatic longint win_min(input int ow, input bit sgn);
        if (sgn)
            return -(64'sd1 <<< (ow - 1));
        return 64'sd0;
    endfunction

endpackage

// File: rtl/float_rounder_lane.sv
// float_rounder_lane: one channel of rounding, range check
// and overflow flagging, pipelined behind a raw-sample register.
module float_rounder_lane
    import float_rounder_pkg::*;
#(
    parameter int IWIDTH     = 16,
    parameter int OWIDTH     = 8,
    parameter int PIPELINE   = 3,
    parameter int SATURATE   = 1,
    parameter bit SIGNED_REP = 1'b1,
    parameter int SW         = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [SW-1:0]     shift_i,
    input  logic [IWIDTH-1:0] data_i,
    output logic [OWIDTH-1:0] data_o,
    output logic              ovf_o
);

    // Two guard bits so the rounding carry survives to the range check.
    localparam int RW = IWIDTH + 2;
    localparam int NS = PIPELINE - 1;
    localparam logic signed [RW-1:0] MAXV = RW'(win_max(OWIDTH, SIGNED_REP));
    localparam logic signed [RW-1:0] MINV = RW'(win_min(OWIDTH, SIGNED_REP));

    logic [IWIDTH-1:0]    x_q;
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] fl;
    logic signed [RW-1:0] rr;
    logic [RW-1:0]        frac;
    logic [RW-1:0]        half;
    logic [RW-1:0]        mask;
    logic                 inc;
    logic [OWIDTH-1:0]    res_d;
    logic                 ovf_d;
    logic [OWIDTH-1:0]    dat_q [NS];
    logic [NS-1:0]        ovf_q;

    // Stage 1: capture the raw sample alongside the shared mode/shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            x_q <= '0;
        else if (en_i)
            x_q <= data_i;
    end

    // Round the stage-1 sample, then range check and clamp or wrap.
    always_comb begin
        xe   = {{2{SIGNED_REP & x_q[IWIDTH-1]}}, x_q};
        mask = (RW'(1) << shift_i) - RW'(1);
        half = (shift_i == '0) ? '0 : (RW'(1) << (shift_i - SW'(1)));
        fl   = xe >>> shift_i;
        frac = xe & mask;
        inc  = 1'b0;
        if (shift_i != '0) begin
            case (mode_i)
                RND_TRUNC:      inc = 1'b0;
                RND_CONVERGENT: inc = (frac > half) ||
                                      ((frac == half) && fl[0]);
                default:        inc = (frac >= half);
            endcase
        end
        rr    = fl + $signed({{(RW-1){1'b0}}, inc});
        ovf_d = (rr > MAXV) || (rr < MINV);
        res_d = rr[OWIDTH-1:0];
        if (ovf_d && (SATURATE != 0))
            res_d = (rr > MAXV) ? MAXV[OWIDTH-1:0] : MINV[OWIDTH-1:0];
    end

    // Carry the result and its flag through the remaining stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NS; i++)
                dat_q[i] <= '0;
            ovf_q <= '0;
        end else if (en_i) begin
            dat_q[0] <= res_d;
            ovf_q[0] <= ovf_d;
            for (int i = 1; i < NS; i++) begin
                dat_q[i] <= dat_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign data_o = dat_q[NS-1];
    assign ovf_o  = ovf_q[NS-1];

endmodule

// File: rtl/float_rounder_mc.sv
// float_rounder_mc: multi-channel window select and rounding with
// saturation/wrap, per-sample and sticky overflow, valid pipeline.
module float_rounder_mc
    import float_rounder_pkg::*;
#(
    parameter int    IWIDTH   = 16,
    parameter int    OWIDTH   = 8,
    parameter int    CHANNELS = 4,
    parameter string SIGNREP  = "SIGNED",
    parameter int    PIPELINE = 3,
    parameter int    SATURATE = 1
) (
    input  logic                                 rst,
    input  logic                                 clk,
    input  logic                                 clkena,
    input  logic [1:0]                           mode,
    input  logic [$clog2(IWIDTH-OWIDTH+1)-1:0]   offset,
    input  logic                                 ovf_clr,
    input  logic                                 i_valid,
    input  logic [CHANNELS*IWIDTH-1:0]           i_data,
    output logic                                 o_valid,
    output logic [CHANNELS*OWIDTH-1:0]           o_data,
    output logic [CHANNELS-1:0]                  o_ovf,
    output logic [CHANNELS-1:0]                  ovf_sticky
);

    localparam int            SW        = $clog2(IWIDTH-OWIDTH+1);
    localparam logic [SW-1:0] MAXK      = SW'(IWIDTH-OWIDTH);
    localparam bit            IS_SIGNED = (SIGNREP == "SIGNED");

    logic [1:0]          mode_q;
    logic [SW-1:0]       shift_d;
    logic [SW-1:0]       shift_q;
    logic [PIPELINE-1:0] vld_q;
    logic [CHANNELS-1:0] sticky_d;
    logic [CHANNELS-1:0] sticky_q;

    // Clamp the offset and turn it into a discarded-LSB count.
    always_comb begin
        shift_d = (offset > MAXK) ? '0 : (MAXK - offset);
    end

    // Stage-1 control registers shared by all lanes, plus valid chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= '0;
            shift_q <= '0;
            vld_q   <= '0;
        end else if (clkena) begin
            mode_q  <= mode;
            shift_q <= shift_d;
            vld_q   <= {vld_q[PIPELINE-2:0], i_valid};
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        float_rounder_lane #(
            .IWIDTH    (IWIDTH),
            .OWIDTH    (OWIDTH),
            .PIPELINE  (PIPELINE),
            .SATURATE  (SATURATE),
            .SIGNED_REP(IS_SIGNED),
            .SW        (SW)
        ) u_lane (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (clkena),
            .mode_i (mode_q),
            .shift_i(shift_q),
            .data_i (i_data[c*IWIDTH +: IWIDTH]),
            .data_o (o_data[c*OWIDTH +: OWIDTH]),
            .ovf_o  (o_ovf[c])
        );
    end

    assign o_valid = vld_q[PIPELINE-1];

    // Clear ignores the enable; a set on the same edge beats it.
    always_comb begin
        sticky_d = ovf_clr ? '0 : sticky_q;
        if (clkena && o_valid)
            sticky_d = sticky_d | o_ovf;
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sticky_q <= '0;
        else
            sticky_q <= sticky_d;
    end

    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_float_rounder_mc.sv
// tb_float_rounder_mc: directed table plus hand sequences for
// sticky, freeze, enable-gapped stream and async reset.
module tb_float_rounder_mc;

    localparam int IW = 8;
    localparam int OW = 4;
    localparam int CH = 2;
    localparam int PL = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clkena = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             i_valid = 1'b0;
    logic [1:0]       mode = '0;
    logic [2:0]       offset = '0;
    logic [CH*IW-1:0] i_data = '0;
    logic             o_valid, w_valid;
    logic [CH*OW-1:0] o_data, w_data;
    logic [CH-1:0]    o_ovf, w_ovf, sticky, w_sticky;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] m;
        logic [2:0] off;
        logic [7:0] x0, x1;
        logic [3:0] e0, e1, w0, w1;
        logic [1:0] ov;
    } vec_t;

    typedef struct {
        logic [3:0] d0, d1, w0, w1;
        logic [1:0] ov;
        int         ed;
    } exp_t;

    vec_t tv[$];
    exp_t sq[$];

    always #5 clk = ~clk;

    float_rounder_mc #(
        .IWIDTH(IW), .OWIDTH(OW), .CHANNELS(CH),
        .SIGNREP("SIGNED"), .PIPELINE(PL), .SATURATE(1)
    ) dut (
        .rst(rst), .clk(clk), .clkena(clkena), .mode(mode),
        .offset(offset), .ovf_clr(ovf_clr), .i_valid(i_valid),
        .i_data(i_data), .o_valid(o_valid), .o_data(o_data),
        .o_ovf(o_ovf), .ovf_sticky(sticky)
    );

    float_rounder_mc #(
        .IWIDTH(IW), .OWIDTH(OW), .CHANNELS(CH),
        .SIGNREP("SIGNED"), .PIPELINE(PL), .SATURATE(0)
    ) dut_w (
        .rst(rst), .clk(clk), .clkena(clkena), .mode(mode),
        .offset(offset), .ovf_clr(ovf_clr), .i_valid(i_valid),
        .i_data(i_data), .o_valid(w_valid), .o_data(w_data),
        .o_ovf(w_ovf), .ovf_sticky(w_sticky)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int m, input int off, input int x0,
                       input int x1, input int e0, input int e1,
                       input int w0, input int w1, input int ov);
        vec_t v;
        v.m = 2'(m);   v.off = 3'(off);
        v.x0 = 8'(x0); v.x1 = 8'(x1);
        v.e0 = 4'(e0); v.e1 = 4'(e1);
        v.w0 = 4'(w0); v.w1 = 4'(w1);
        v.ov = 2'(ov);
        tv.push_back(v);
    endtask

    // Reference rounding in real arithmetic.
    function automatic int rnd(input int x, input int m, input int off);
        int  k = (off > 4) ? 4 : off;
        int  s = 4 - k;
        real p = 1.0;
        real q, f;
        repeat (s) p = p * 2.0;
        q = x / p;
        f = $floor(q);
        if (m == 1 || m == 3) begin
            f = $floor(q + 0.5);
        end else if (m == 2) begin
            if (q - f > 0.5)
                f = f + 1.0;
            else if (q - f == 0.5 && ($rtoi(f) % 2 != 0))
                f = f + 1.0;
        end
        return $rtoi(f);
    endfunction

    function automatic logic [3:0] sat4(input int r);
        if (r > 7)  return 4'd7;
        if (r < -8) return 4'h8;
        return 4'(r);
    endfunction

    function automatic logic ovf4(input int r);
        return (r > 7) || (r < -8);
    endfunction

    // One sample in; checks it is absent after 2 edges, present after 3.
    task automatic send(input logic [1:0] m, input logic [2:0] off,
                        input logic [7:0] x0, input logic [7:0] x1);
        @(negedge clk);
        mode = m; offset = off; i_data = {x1, x0};
        i_valid = 1'b1; clkena = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk("early_valid", 32'(o_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(o_valid), 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, edges, cyc, tail, xi;
        bit en, last_en;
        exp_t e;

        // Reset state while inputs are active.
        clkena = 1'b1; i_valid = 1'b1; i_data = 16'h7F7F; mode = 2'd1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_sticky", 32'(sticky), 0);
        i_valid = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);

        //   m off  x0    x1   e0  e1  w0   w1  ov
        add(0, 2,  18,   22,  4,  5,  4,   5,  0);
        add(1, 2,  18,   22,  5,  6,  5,   6,  0);
        add(2, 2,  18,   22,  4,  6,  4,   6,  0);
        add(0, 2, -18,    0, -5,  0, -5,   0,  0);
        add(1, 2, -18,    3, -4,  1, -4,   1,  0);
        add(2, 2, -18,    6, -4,  2, -4,   2,  0);
        add(3, 2,  18,  -22,  5, -5,  5,  -5,  0);
        add(1, 4,   5,    9,  5,  7,  5,   9,  2);
        add(1, 6,   5,    9,  5,  7,  5,   9,  2);
        add(1, 2,  18, -128,  5, -8,  5,   0,  2);
        add(2, 0, 127, -128,  7, -8,  8,  -8,  1);
        add(0, 3,  -1,  100, -1,  7, -1,   2,  2);

        foreach (tv[i]) begin
            send(tv[i].m, tv[i].off, tv[i].x0, tv[i].x1);
            chk($sformatf("v%0d_d0", i), 32'(o_data[3:0]), 32'(tv[i].e0));
            chk($sformatf("v%0d_d1", i), 32'(o_data[7:4]), 32'(tv[i].e1));
            chk($sformatf("v%0d_ovf", i), 32'(o_ovf), 32'(tv[i].ov));
            chk($sformatf("v%0d_w0", i), 32'(w_data[3:0]), 32'(tv[i].w0));
            chk($sformatf("v%0d_w1", i), 32'(w_data[7:4]), 32'(tv[i].w1));
            chk($sformatf("v%0d_wovf", i), 32'(w_ovf), 32'(tv[i].ov));
        end

        // Sticky: set one edge after the flagged output, clear gated off.
        repeat (3) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky_clr0", 32'(sticky), 0);
        send(2'd1, 3'd2, 8'd30, 8'd0);
        chk("ovf_d0", 32'(o_data[3:0]), 7);
        chk("ovf_flag", 32'(o_ovf), 1);
        chk("sticky_pre", 32'(sticky), 0);
        @(negedge clk);
        chk("sticky_set", 32'(sticky), 1);
        repeat (2) @(negedge clk);
        chk("sticky_hold", 32'(sticky), 1);
        clkena = 1'b0; ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0; clkena = 1'b1;
        chk("sticky_clr_noen", 32'(sticky), 0);
        send(2'd1, 3'd2, 8'd30, 8'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky_set_wins", 32'(sticky), 1);

        // Freeze: clkena low holds valid and data despite new input.
        repeat (3) @(negedge clk);
        send(2'd0, 3'd2, 8'd22, 8'd18);
        clkena = 1'b0; i_valid = 1'b1; i_data = 16'h0101;
        repeat (3) @(negedge clk);
        chk("frz_valid", 32'(o_valid), 1);
        chk("frz_data", 32'(o_data), 32'h45);
        i_valid = 1'b0; clkena = 1'b1;
        repeat (4) @(negedge clk);

        // Stream 0..255 with random enable gaps against the model.
        sent = 0; got = 0; edges = 0; cyc = 0; tail = 0; last_en = 1'b0;
        while (tail < 6 && cyc < 4000) begin
            if (last_en) begin
                if (o_valid) begin
                    if (sq.size() == 0) begin
                        chk("extra_valid", 32'(o_valid), 0);
                    end else begin
                        e = sq.pop_front();
                        chk("s_d0", 32'(o_data[3:0]), 32'(e.d0));
                        chk("s_d1", 32'(o_data[7:4]), 32'(e.d1));
                        chk("s_ovf", 32'(o_ovf), 32'(e.ov));
                        chk("s_w0", 32'(w_data[3:0]), 32'(e.w0));
                        chk("s_w1", 32'(w_data[7:4]), 32'(e.w1));
                        chk("s_lat", 32'(edges - e.ed), PL - 1);
                        got++;
                    end
                end
                if (sent == 256 && sq.size() == 0)
                    tail++;
            end
            en = ($urandom_range(0, 3) != 0);
            clkena = en;
            if (en) begin
                if (sent < 256) begin
                    mode = 2'(sent % 4);
                    offset = 3'((sent / 4) % 8);
                    i_data = {8'((sent * 37 + 11) & 255), 8'(sent)};
                    i_valid = 1'b1;
                    xi = sent;
                    if (xi > 127) xi -= 256;
                    e.d0 = sat4(rnd(xi, sent % 4, (sent / 4) % 8));
                    e.w0 = 4'(rnd(xi, sent % 4, (sent / 4) % 8));
                    e.ov[0] = ovf4(rnd(xi, sent % 4, (sent / 4) % 8));
                    xi = (sent * 37 + 11) & 255;
                    if (xi > 127) xi -= 256;
                    e.d1 = sat4(rnd(xi, sent % 4, (sent / 4) % 8));
                    e.w1 = 4'(rnd(xi, sent % 4, (sent / 4) % 8));
                    e.ov[1] = ovf4(rnd(xi, sent % 4, (sent / 4) % 8));
                    e.ed = edges + 1;
                    sq.push_back(e);
                    sent++;
                end else begin
                    i_valid = 1'b0;
                end
                edges++;
            end
            last_en = en;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 4000)
            chk("stream_timeout", 32'(cyc), 0);
        chk("stream_count", 32'(got), 256);
        clkena = 1'b1; i_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Async reset with samples in flight; no stale output after.
        mode = 2'd1; offset = 3'd2; i_data = {8'd40, 8'd30};
        i_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 32'(o_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_data", 32'(o_data), 0);
        chk("arst_ovf", 32'(o_ovf), 0);
        chk("arst_sticky", 32'(sticky), 0);
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stale_%0d", i), 32'(o_valid), 0);
        end
        send(2'd1, 3'd2, 8'd18, 8'h80);
        chk("post_d0", 32'(o_data[3:0]), 5);
        chk("post_d1", 32'(o_data[7:4]), 8);
        chk("post_ovf", 32'(o_ovf), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_rounder_mc.md
Name: float_rounder_mc

Overview:
Multi-channel successor to float_rounder. It selects an OWIDTH-bit window from each IWIDTH-bit channel sample, positioned by a runtime MSB offset, and applies a runtime-selectable rounding mode. Results that exceed the window saturate (or wrap), with per-sample and sticky overflow flags. The block sits between wide accumulators/filters and narrow downstream datapaths. It carries a valid qualifier through a clock-enabled fixed-latency pipeline.

Parameters:
IWIDTH, 16, input sample width per channel (> OWIDTH)
OWIDTH, 8, output sample width per channel
CHANNELS, 4, number of parallel channels (>= 1)
SIGNREP, "SIGNED", "SIGNED" | "UNSIGNED" sample representation
PIPELINE, 3, latency in enabled clock cycles (>= 2)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low OWIDTH bits)

Ports:
rst  input  1  asynchronous reset, active-low
clk  input  1  clock
clkena  input  1  clock enable for the whole pipeline
mode  input  2  rounding mode: 0 truncate (floor), 1 round half up, 2 convergent (ties to even), 3 treated as 1
offset  input  $clog2(IWIDTH-OWIDTH+1)  number of input MSBs dropped above the output window
ovf_clr  input  1  synchronous clear of ovf_sticky
i_valid  input  1  input sample qualifier
i_data  input  CHANNELS*IWIDTH  channel c occupies bits [c*IWIDTH +: IWIDTH]
o_valid  output  1  output sample qualifier
o_data  output  CHANNELS*OWIDTH  channel c occupies bits [c*OWIDTH +: OWIDTH]
o_ovf  output  CHANNELS  per-channel overflow of the current output sample
ovf_sticky  output  CHANNELS  per-channel accumulated overflow

Behaviour:
- Reset (rst=0, async): all pipeline stages, o_data, o_valid, o_ovf and ovf_sticky go to 0 immediately. Any in-flight samples are discarded.
- Offset clamp: k = min(offset, IWIDTH-OWIDTH). Discarded LSB count s = IWIDTH-OWIDTH-k.
- Value q = x / 2^s, where x is the input interpreted per SIGNREP.
  - mode 0: r = floor(q)
  - mode 1: r = floor(q + 1/2)
  - mode 2: nearest value, with ties going to the even result
  - s = 0: r = x; no rounding occurs.
- Range check is on the full-precision r against the OWIDTH range: signed [-2^(OWIDTH-1), 2^(OWIDTH-1)-1], unsigned [0, 2^OWIDTH-1].
  - Out of range: o_ovf[c]=1. With SATURATE=1, output clamps to max/min; with SATURATE=0, output is r[OWIDTH-1:0].
- Internal rounding arithmetic carries at least IWIDTH+1 bits, so a rounding carry is never lost before the range check.
- mode and offset are sampled together with i_data in stage 1 and travel with the sample. A change to either affects only samples entered on or after that edge.
- Latency: an input presented at enabled edge n appears at the outputs after the PIPELINE-th enabled edge counting from n.
- clkena=0 freezes every stage, including the valid chain and outputs. Disabled cycles do not count toward latency.
- Data registers load on every enabled edge regardless of valid. o_data and o_ovf are meaningful only when o_valid=1.
- ovf_sticky[c]:
  - Set on an enabled edge where o_valid & o_ovf[c] hold.
  - Cleared by ovf_clr=1 on any edge, independent of clkena.
  - If set and clear happen on the same edge, set wins.
- No backpressure: the block is always ready for new input.

Decomposition:
- Package float_rounder_pkg:
  - enum round_mode_t {RND_TRUNC=0, RND_HALF_UP=1, RND_CONVERGENT=2}
  - helper function for window-limit constants
- Sub-module float_rounder_lane: one channel of pipelined rounding, range check and o_ovf.
- Top level contains:
  - CHANNELS lane instances sharing the mode/offset pipeline
  - the valid shift chain
  - sticky flag logic

Test Plan (IWIDTH=8, OWIDTH=4, SIGNED, CHANNELS=2, PIPELINE=3, SATURATE=1 unless noted):
1. offset=2, x=18 (q=4.5) in all modes -> mode0 4, mode1 5, mode2 4; x=22 (q=5.5) -> 5, 6, 6; each o_valid exactly 3 enabled edges later.
2. offset=2, x=-18 (q=-4.5) -> mode0 -5, mode1 -4, mode2 -4; x=30, mode1 -> r=8, o_data=7, o_ovf=1, ovf_sticky=1 until ovf_clr; set+clr on the same edge keeps sticky=1.
3. offset=4 (s=0): x=5 -> 5, no ovf; x=9 -> 7 with ovf. offset=6 (clamped to 4): identical results. SATURATE=0, x=9 -> o_data=-7 (4'b1001), o_ovf=1.
4. Channel independence: ch0=18, ch1=-128 with offset=2, mode=1 -> ch0 5 no ovf, ch1 -8 with ovf only on bit 1.
5. Stream i=0..255 with clkena toggling pseudo-randomly -> every output equals the reference-model result; o_valid count equals i_valid count; latency is 3 enabled edges.
6. Drop rst mid-stream -> all outputs 0 asynchronously; after release, the first o_valid appears exactly 3 enabled edges after the first new i_valid, with no stale samples.
